// File: rtl/dmac_pkg.sv
// Shared AHB-Lite encodings and responder state type for the DMA subsystem.
package dmac_pkg;

  localparam logic [1:0] IDLE    = 2'b00;
  localparam logic [1:0] BUSY    = 2'b01;
  localparam logic [1:0] NON_SEQ = 2'b10;
  localparam logic [1:0] SEQ     = 2'b11;

  localparam logic [1:0] RESP_OKAY  = 2'b00;
  localparam logic [1:0] RESP_ERROR = 2'b01;

  localparam logic [2:0] HSIZE_BYTE = 3'd0;
  localparam logic [2:0] HSIZE_HALF = 3'd1;
  localparam logic [2:0] HSIZE_WORD = 3'd2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_LAST,
    ST_ERR1,
    ST_ERR2
  } resp_state_t;

  // Little-endian byte-lane enables for a 32-bit bus.
  function automatic logic [3:0] byte_lanes(input logic [2:0] size, input logic [1:0] addr);
    case (size)
      HSIZE_BYTE: byte_lanes = 4'b0001 << addr;
      HSIZE_HALF: byte_lanes = addr[1] ? 4'b1100 : 4'b0011;
      default:    byte_lanes = 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/ahb_mem_responder_if.sv
// AHB-Lite bus bundle between a master and the memory responder.
interface ahb_mem_responder_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              HSel;
  logic [ADDR_W-1:0] HAddr;
  logic [1:0]        HTrans;
  logic              HWrite;
  logic [2:0]        HSize;
  logic [DATA_W-1:0] HWData;
  logic              HReady;
  logic [DATA_W-1:0] HRData;
  logic              HReadyOut;
  logic [1:0]        HResp;

  modport master (
    output HSel, HAddr, HTrans, HWrite, HSize, HWData, HReady,
    input  HRData, HReadyOut, HResp
  );

  modport slave (
    input  HSel, HAddr, HTrans, HWrite, HSize, HWData, HReady,
    output HRData, HReadyOut, HResp
  );
endinterface

// File: rtl/ahb_mem_array.sv
// Word-organised memory with per-byte write enables and an asynchronous read port.
module ahb_mem_array #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 1024,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [3:0]        be_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [AW-1:0]     raddr_i,
  output logic [DATA_W-1:0] rdata_o
);
  logic [DATA_W-1:0] mem_q [DEPTH];

  // Byte-masked write; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (we_i) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (be_i[b]) mem_q[waddr_i][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
  end

  assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/ahb_mem_responder.sv
// AHB-Lite memory responder: decodes transfers, inserts wait states,
// returns two-cycle ERROR responses and drives the backing memory.
module ahb_mem_responder
  import dmac_pkg::*;
#(
  parameter int                ADDR_W      = 32,
  parameter int                DATA_W      = 32,
  parameter int                MEM_DEPTH   = 1024,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
  parameter int                WAIT_STATES = 0
) (
  input logic                 clk,
  input logic                 rst,
  ahb_mem_responder_if.slave  bus
);
  localparam int                AW        = $clog2(MEM_DEPTH);
  localparam logic [ADDR_W-1:0] MEM_BYTES = ADDR_W'(MEM_DEPTH * 4);

  resp_state_t       state_q, state_d;
  logic [3:0]        wcnt_q, wcnt_d;
  logic              dp_valid_q, dp_write_q;
  logic [2:0]        dp_size_q;
  logic [AW+1:0]     dp_addr_q;

  logic              ready_out;
  logic [1:0]        resp;
  logic              accept;
  logic              acc_err;
  logic [ADDR_W:0]   diff;
  logic              mem_we;
  logic [DATA_W-1:0] mem_rdata;
  logic              unused_htrans0;

  // SEQ and NONSEQ are handled identically by a flat memory.
  assign unused_htrans0 = bus.HTrans[0];

  // Address-phase decode; the extra top bit of diff flags addresses below the base.
  assign diff   = {1'b0, bus.HAddr} - {1'b0, BASE_ADDR};
  assign accept = bus.HSel & bus.HReady & bus.HTrans[1] & ready_out;

  // Range, size and alignment checks on the address phase.
  always_comb begin
    acc_err = 1'b0;
    if (diff[ADDR_W] || (diff[ADDR_W-1:0] >= MEM_BYTES))         acc_err = 1'b1;
    if (bus.HSize > HSIZE_WORD)                                  acc_err = 1'b1;
    if ((bus.HSize == HSIZE_HALF) && bus.HAddr[0])               acc_err = 1'b1;
    if ((bus.HSize == HSIZE_WORD) && (bus.HAddr[1:0] != 2'b00))  acc_err = 1'b1;
  end

  // Next-state and response outputs.
  always_comb begin
    state_d   = state_q;
    wcnt_d    = wcnt_q;
    ready_out = 1'b1;
    resp      = RESP_OKAY;
    case (state_q)
      ST_WAIT: begin
        ready_out = 1'b0;
        if (wcnt_q == 4'd0) state_d = ST_LAST;
        else                wcnt_d  = wcnt_q - 4'd1;
      end
      ST_ERR1: begin
        ready_out = 1'b0;
        resp      = RESP_ERROR;
        state_d   = ST_ERR2;
      end
      ST_ERR2: resp = RESP_ERROR;
      default: ;
    endcase
    // Any ready cycle ends the current data phase, so IDLE/LAST/ERR2 share one accept rule.
    if (ready_out) begin
      state_d = ST_IDLE;
      if (accept) begin
        if (acc_err) begin
          state_d = ST_ERR1;
        end else if (WAIT_STATES > 0) begin
          state_d = ST_WAIT;
          wcnt_d  = 4'(WAIT_STATES - 1);
        end
      end
    end
  end

  // State and wait-counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
    end
  end

  // Data-phase registers load whenever the previous data phase completes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dp_valid_q <= 1'b0;
      dp_write_q <= 1'b0;
      dp_size_q  <= HSIZE_BYTE;
      dp_addr_q  <= '0;
    end else if (ready_out) begin
      dp_valid_q <= accept & ~acc_err;
      if (accept) begin
        dp_write_q <= bus.HWrite;
        dp_size_q  <= bus.HSize;
        dp_addr_q  <= diff[AW+1:0];
      end
    end
  end

  assign mem_we = dp_valid_q & dp_write_q & ready_out;

  ahb_mem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (MEM_DEPTH)
  ) u_mem (
    .clk     (clk),
    .we_i    (mem_we),
    .be_i    (byte_lanes(dp_size_q, dp_addr_q[1:0])),
    .waddr_i (dp_addr_q[AW+1:2]),
    .wdata_i (bus.HWData),
    .raddr_i (dp_addr_q[AW+1:2]),
    .rdata_o (mem_rdata)
  );

  assign bus.HReadyOut = ready_out;
  assign bus.HResp     = resp;
  assign bus.HRData    = (dp_valid_q && !dp_write_q) ? mem_rdata : '0;
endmodule

// File: tb/tb_ahb_mem_responder.sv
// Directed bench for ahb_mem_responder with 0, 3 and 5 wait-state instances.
module tb_ahb_mem_responder;
  import dmac_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        m_sel = 1'b0;
  logic [31:0] m_addr = '0;
  logic [1:0]  m_trans = IDLE;
  logic        m_write = 1'b0;
  logic [2:0]  m_size = HSIZE_WORD;
  logic [31:0] m_wdata = '0;
  logic [1:0]  tgt = 2'd0;
  logic        cur_ready;
  logic [1:0]  cur_resp;
  logic [31:0] cur_rdata;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  ahb_mem_responder_if #(.ADDR_W(32), .DATA_W(32)) if0 ();
  ahb_mem_responder_if #(.ADDR_W(32), .DATA_W(32)) if3 ();
  ahb_mem_responder_if #(.ADDR_W(32), .DATA_W(32)) if5 ();

  assign if0.HSel = m_sel && (tgt == 2'd0);
  assign if3.HSel = m_sel && (tgt == 2'd1);
  assign if5.HSel = m_sel && (tgt == 2'd2);
  assign if0.HAddr = m_addr;  assign if3.HAddr = m_addr;  assign if5.HAddr = m_addr;
  assign if0.HTrans = m_trans; assign if3.HTrans = m_trans; assign if5.HTrans = m_trans;
  assign if0.HWrite = m_write; assign if3.HWrite = m_write; assign if5.HWrite = m_write;
  assign if0.HSize = m_size;  assign if3.HSize = m_size;  assign if5.HSize = m_size;
  assign if0.HWData = m_wdata; assign if3.HWData = m_wdata; assign if5.HWData = m_wdata;
  assign if0.HReady = if0.HReadyOut;
  assign if3.HReady = if3.HReadyOut;
  assign if5.HReady = if5.HReadyOut;

  ahb_mem_responder #(.WAIT_STATES(0)) dut0 (.clk(clk), .rst(rst), .bus(if0.slave));
  ahb_mem_responder #(.WAIT_STATES(3)) dut3 (.clk(clk), .rst(rst), .bus(if3.slave));
  ahb_mem_responder #(.WAIT_STATES(5)) dut5 (.clk(clk), .rst(rst), .bus(if5.slave));

  always_comb begin
    cur_ready = if0.HReadyOut;
    cur_resp  = if0.HResp;
    cur_rdata = if0.HRData;
    if (tgt == 2'd1) begin
      cur_ready = if3.HReadyOut; cur_resp = if3.HResp; cur_rdata = if3.HRData;
    end else if (tgt == 2'd2) begin
      cur_ready = if5.HReadyOut; cur_resp = if5.HResp; cur_rdata = if5.HRData;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One non-pipelined transfer; records response in first and last data-phase cycle.
  task automatic single(input logic wr, input logic [31:0] addr, input logic [2:0] size,
                        input logic [31:0] wdata, output logic [31:0] rdata,
                        output logic [1:0] first_resp, output logic [1:0] resp,
                        output int lat, output int lows);
    m_sel = 1'b1; m_trans = NON_SEQ; m_write = wr; m_addr = addr; m_size = size;
    tick();
    m_sel = 1'b0; m_trans = IDLE; m_wdata = wdata;
    lat = 0; lows = 0; rdata = '0; resp = 2'b11; first_resp = cur_resp;
    for (int i = 0; i < 40; i++) begin
      lat++;
      if (!cur_ready) begin
        lows++;
        tick();
      end else begin
        rdata = cur_rdata;
        resp  = cur_resp;
        break;
      end
    end
    tick();
  endtask

  task automatic test_reset();
    logic [31:0] all_rdata;
    logic [5:0]  all_resp;
    logic [2:0]  all_ready;
    all_rdata = if0.HRData | if3.HRData | if5.HRData;
    all_resp  = {if0.HResp, if3.HResp, if5.HResp};
    all_ready = {if0.HReadyOut, if3.HReadyOut, if5.HReadyOut};
    checks++; if (all_ready !== 3'b111) begin errors++; $display("FAIL reset_ready: got %b expected 111", all_ready); end
    checks++; if (all_resp !== 6'b0) begin errors++; $display("FAIL reset_resp: got %b expected 000000", all_resp); end
    checks++; if (all_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h expected 00000000", all_rdata); end
  endtask

  task automatic test_zero_wait();
    tgt = 2'd0;
    m_sel = 1'b1; m_trans = NON_SEQ; m_write = 1'b1; m_size = HSIZE_WORD; m_addr = 32'h10;
    tick();
    m_wdata = 32'hDEADBEEF; m_write = 1'b0;
    checks++; if (cur_ready !== 1'b1 || cur_resp !== RESP_OKAY) begin errors++;
      $display("FAIL zw_write_phase: got ready=%b resp=%b expected ready=1 resp=00", cur_ready, cur_resp); end
    tick();
    m_sel = 1'b0; m_trans = IDLE;
    checks++; if (cur_ready !== 1'b1 || cur_resp !== RESP_OKAY) begin errors++;
      $display("FAIL zw_read_phase: got ready=%b resp=%b expected ready=1 resp=00", cur_ready, cur_resp); end
    checks++; if (cur_rdata !== 32'hDEADBEEF) begin errors++;
      $display("FAIL zw_read_data: got %h expected deadbeef", cur_rdata); end
    tick();
    checks++; if (cur_rdata !== 32'h0) begin errors++;
      $display("FAIL zw_idle_rdata: got %h expected 00000000", cur_rdata); end
  endtask

  task automatic test_wait_states();
    logic [31:0] rd; logic [1:0] fr, rs; int lat, lows;
    tgt = 2'd1;
    single(1'b1, 32'h40, HSIZE_WORD, 32'hCAFEF00D, rd, fr, rs, lat, lows);
    checks++; if (lat !== 4 || lows !== 3) begin errors++;
      $display("FAIL ws_write_latency: got lat=%0d lows=%0d expected lat=4 lows=3", lat, lows); end
    single(1'b0, 32'h40, HSIZE_WORD, 32'h0, rd, fr, rs, lat, lows);
    checks++; if (lat !== 4 || lows !== 3) begin errors++;
      $display("FAIL ws_read_latency: got lat=%0d lows=%0d expected lat=4 lows=3", lat, lows); end
    checks++; if (rd !== 32'hCAFEF00D || rs !== RESP_OKAY) begin errors++;
      $display("FAIL ws_read_data: got %h/%b expected cafef00d/00", rd, rs); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd; logic [1:0] fr, rs; int lat, lows;
    logic [31:0] exp_w [3];
    exp_w[0] = 32'd1; exp_w[1] = 32'd2; exp_w[2] = 32'd3;
    tgt = 2'd0;
    m_sel = 1'b1; m_write = 1'b1; m_size = HSIZE_WORD;
    m_trans = NON_SEQ; m_addr = 32'h0; tick();
    m_wdata = 32'd1; m_trans = SEQ; m_addr = 32'h4; tick();
    m_wdata = 32'd2; m_trans = BUSY; m_addr = 32'h8; tick();
    checks++; if (cur_ready !== 1'b1 || cur_resp !== RESP_OKAY) begin errors++;
      $display("FAIL busy_phase: got ready=%b resp=%b expected ready=1 resp=00", cur_ready, cur_resp); end
    m_wdata = 32'hBAD0BAD0; m_trans = SEQ; m_addr = 32'h8; tick();
    m_wdata = 32'd3; m_trans = IDLE; m_sel = 1'b0; tick();
    for (int i = 0; i < 3; i++) begin
      single(1'b0, 32'(i * 4), HSIZE_WORD, 32'h0, rd, fr, rs, lat, lows);
      checks++; if (rd !== exp_w[i] || lat !== 1) begin errors++;
        $display("FAIL burst_word%0d: got %h lat=%0d expected %h lat=1", i, rd, lat, exp_w[i]); end
    end
  endtask

  task automatic test_lanes();
    logic [31:0] rd; logic [1:0] fr, rs; int lat, lows;
    tgt = 2'd0;
    single(1'b1, 32'h20, HSIZE_WORD, 32'h11223344, rd, fr, rs, lat, lows);
    single(1'b1, 32'h21, HSIZE_BYTE, 32'hEEEEAAEE, rd, fr, rs, lat, lows);
    checks++; if (rs !== RESP_OKAY) begin errors++; $display("FAIL byte_resp: got %b expected 00", rs); end
    single(1'b1, 32'h22, HSIZE_HALF, 32'hBBCCDDDD, rd, fr, rs, lat, lows);
    single(1'b0, 32'h20, HSIZE_WORD, 32'h0, rd, fr, rs, lat, lows);
    checks++; if (rd !== 32'hBBCCAA44) begin errors++; $display("FAIL lanes_word: got %h expected bbccaa44", rd); end
  endtask

  task automatic test_errors();
    logic [31:0] rd; logic [1:0] fr, rs; int lat, lows;
    tgt = 2'd0;
    single(1'b0, 32'hFFC, HSIZE_WORD, 32'h0, rd, fr, rs, lat, lows);
    checks++; if (rs !== RESP_OKAY || lat !== 1) begin errors++;
      $display("FAIL last_word_ok: got resp=%b lat=%0d expected resp=00 lat=1", rs, lat); end
    single(1'b0, 32'h1000, HSIZE_WORD, 32'h0, rd, fr, rs, lat, lows);
    checks++; if (fr !== RESP_ERROR || rs !== RESP_ERROR || lat !== 2 || lows !== 1 || rd !== 32'h0) begin errors++;
      $display("FAIL err_range: got %b/%b lat=%0d lows=%0d rd=%h expected 01/01 lat=2 lows=1 rd=0", fr, rs, lat, lows, rd); end
    single(1'b1, 32'h2, HSIZE_WORD, 32'hFFFFFFFF, rd, fr, rs, lat, lows);
    checks++; if (fr !== RESP_ERROR || rs !== RESP_ERROR || lat !== 2 || lows !== 1) begin errors++;
      $display("FAIL err_align: got %b/%b lat=%0d lows=%0d expected 01/01 lat=2 lows=1", fr, rs, lat, lows); end
    single(1'b1, 32'h4, 3'd3, 32'hFFFFFFFF, rd, fr, rs, lat, lows);
    checks++; if (fr !== RESP_ERROR || rs !== RESP_ERROR || lat !== 2 || lows !== 1) begin errors++;
      $display("FAIL err_size: got %b/%b lat=%0d lows=%0d expected 01/01 lat=2 lows=1", fr, rs, lat, lows); end
    single(1'b0, 32'h0, HSIZE_WORD, 32'h0, rd, fr, rs, lat, lows);
    checks++; if (rd !== 32'd1) begin errors++; $display("FAIL err_word0_kept: got %h expected 00000001", rd); end
    single(1'b0, 32'h4, HSIZE_WORD, 32'h0, rd, fr, rs, lat, lows);
    checks++; if (rd !== 32'd2) begin errors++; $display("FAIL err_word1_kept: got %h expected 00000002", rd); end
  endtask

  task automatic test_reset_mid_wait();
    logic [31:0] rd; logic [1:0] fr, rs; int lat, lows;
    tgt = 2'd2;
    single(1'b1, 32'h80, HSIZE_WORD, 32'h12345678, rd, fr, rs, lat, lows);
    checks++; if (lat !== 6 || lows !== 5) begin errors++;
      $display("FAIL ws5_latency: got lat=%0d lows=%0d expected lat=6 lows=5", lat, lows); end
    m_sel = 1'b1; m_trans = NON_SEQ; m_write = 1'b1; m_size = HSIZE_WORD; m_addr = 32'h80;
    tick();
    m_sel = 1'b0; m_trans = IDLE; m_wdata = 32'hFFFFFFFF;
    tick();
    checks++; if (cur_ready !== 1'b0) begin errors++; $display("FAIL mid_wait_stall: got %b expected 0", cur_ready); end
    #2 rst = 1'b0;
    #1;
    checks++; if (cur_ready !== 1'b1 || cur_resp !== RESP_OKAY || cur_rdata !== 32'h0) begin errors++;
      $display("FAIL async_reset_out: got ready=%b resp=%b rd=%h expected 1/00/0", cur_ready, cur_resp, cur_rdata); end
    tick();
    tick();
    rst = 1'b1;
    tick();
    single(1'b0, 32'h80, HSIZE_WORD, 32'h0, rd, fr, rs, lat, lows);
    checks++; if (rd !== 32'h12345678) begin errors++; $display("FAIL no_partial_write: got %h expected 12345678", rd); end
  endtask

  initial begin
    rst = 1'b0;
    #12;
    test_reset();
    #3 rst = 1'b1;
    tick();
    test_zero_wait();
    test_wait_states();
    test_back_to_back();
    test_lanes();
    test_errors();
    test_reset_mid_wait();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/ahb_mem_responder.md
Name: ahb_mem_responder

Overview:
AHB-Lite responder (slave) backed by a word-addressed, byte-writable memory. It is the far end of the DMA channel's master bus and serves as the source and destination for DMA transfers in subsystem integration and verification. It decodes NONSEQ, SEQ, BUSY and IDLE, inserts programmable wait states and returns two-cycle ERROR responses.

Parameters:
ADDR_W, 32, HAddr width
DATA_W, 32, data bus width; only 32 is supported
MEM_DEPTH, 1024, number of DATA_W words; power of 2
BASE_ADDR, 32'h0000_0000, first byte address decoded
WAIT_STATES, 0, wait cycles inserted per OKAY data phase (0..15)

Ports:
clk  in  1  clock; everything is sampled on the rising edge
rst  in  1  asynchronous reset, active-low (asserted when 0)
HSel  in  1  slave select
HAddr  in  ADDR_W  byte address (address phase)
HTrans  in  2  IDLE=00, BUSY=01, NON_SEQ=10, SEQ=11
HWrite  in  1  1 = write
HSize  in  3  0 = byte, 1 = halfword, 2 = word
HWData  in  DATA_W  write data (data phase)
HReady  in  1  bus ready; tied to HReadyOut in a single-slave system
HRData  out  DATA_W  read data
HReadyOut  out  1  0 stalls the current data phase
HResp  out  2  00 = OKAY, 01 = ERROR

Behaviour:
- Reset values: HReadyOut=1, HResp=00, HRData=0, FSM in ST_IDLE, all phase registers cleared. Memory contents are not reset.
- Transfer accept: on a clock edge where HSel & HReady & HTrans[1]=1.
  - On accept, latch address, write flag, size and byte lanes into the data-phase registers.
  - BUSY, IDLE or unselected cycles are never accepted; their data phase is zero-wait OKAY with no memory access.
- Error check at accept:
  - ERROR if the address is out of range: (HAddr - BASE_ADDR) >= MEM_DEPTH*4, or HAddr < BASE_ADDR.
  - ERROR if HSize > 2.
  - ERROR if the address is misaligned: halfword with HAddr[0]=1, or word with HAddr[1:0]!=0.
- FSM states:
  - ST_IDLE: HReadyOut=1, HResp=00.
    - Accept, valid, WAIT_STATES>0 → ST_WAIT; load wait counter with WAIT_STATES-1.
    - Accept, valid, WAIT_STATES=0 → stay in ST_IDLE; the data phase completes in 1 cycle.
    - Accept, error → ST_ERR1.
  - ST_WAIT: HReadyOut=0, HResp=00; counter decrements each cycle.
    - When the counter is 0, go to ST_LAST.
    - Address-phase signals are ignored in this state because HReady=0.
  - ST_LAST: HReadyOut=1, HResp=00; the data phase completes.
    - A new transfer may be accepted in the same cycle; next state follows the ST_IDLE rules.
  - ST_ERR1: HReadyOut=0, HResp=01 → ST_ERR2. No memory access.
  - ST_ERR2: HReadyOut=1, HResp=01. A new accept is allowed (the master may have replaced it with IDLE); next state follows the ST_IDLE rules.
- Write commit: at the edge that completes a write data phase (HReadyOut=1), HWData byte lanes selected by the latched address/size are written. Little-endian: byte lane = addr[1:0].
- Read data:
  - HRData = mem[latched word index] (combinational) while in a read data phase with OKAY response; otherwise HRData=0.
  - The full word is returned; the master selects the lanes.
- Read-after-write to the same address in consecutive transfers returns the new data. This holds because the write commits on the same edge that the read's address is latched.
- The latency of each OKAY transfer is WAIT_STATES+1 data-phase cycles. An error transfer always takes 2 cycles.
- Reset asserted mid-transfer: the data phase is abandoned, outputs go to their reset values immediately, and no partial write occurs.

Decomposition:
- Shared package dmac_pkg holds:
  - HTrans encodings (IDLE, BUSY, NON_SEQ, SEQ)
  - HResp encodings (RESP_OKAY=2'b00, RESP_ERROR=2'b01)
  - HSize encodings
  - resp_state_t enum (ST_IDLE, ST_WAIT, ST_LAST, ST_ERR1, ST_ERR2)
- One sub-module: ahb_mem_array, a MEM_DEPTH x DATA_W memory with a 4-bit byte-write-enable, one write port and one asynchronous read port.

Test Plan:
- Zero-wait write/read: WAIT_STATES=0. Write NONSEQ word 0xDEADBEEF to 0x10, then read 0x10 → HReadyOut stays 1, HResp=00, HRData=0xDEADBEEF in the read's data phase.
- Wait states: WAIT_STATES=3, single read → HReadyOut low for exactly 3 cycles, then high for 1 with valid data; total 4 data-phase cycles.
- Burst with BUSY: NONSEQ 0x0 → SEQ 0x4 → BUSY → SEQ 0x8, writing 1, 2, 3; read back → words 0..2 = 1, 2, 3; the BUSY data phase is OKAY with no write.
- Byte/halfword lanes: preload 0x11223344 at 0x20; byte write 0xAA to 0x21; halfword write 0xBBCC to 0x22 → word reads 0xBBCCAA44.
- Errors: read at BASE_ADDR+MEM_DEPTH*4, word write to 0x2, HSize=3 → each gives HResp=01 for 2 cycles with HReadyOut 0 then 1; memory unchanged.
- Reset mid-wait: WAIT_STATES=5, assert rst low at wait cycle 2 during a write → HReadyOut=1, HResp=00, HRData=0 immediately; target word unchanged.
